// File: rtl/stack_controller.sv
// Stack sequencer: drives stackpointer / memorystack strobes and the shared bus.
// Optional CLEAR operation (op 11) is built when STACK_CTRL_CLEAR_EN is defined.
module stack_controller #(
    parameter int DEPTH = 65535,
    parameter int DW    = 16
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_req,
    input  logic [1:0]    i_op,
    input  logic [DW-1:0] i_data,
    output logic          o_ready,
    output logic          o_done,
    output logic          o_err,
    output logic [DW-1:0] o_data,
    output logic [16:0]   o_depth,
    output logic          o_full,
    output logic          o_empty,
    output logic [2:0]    o_sp_ctrl,
    output logic          o_mem_w,
    output logic          o_mem_s,
    inout  wire  [DW-1:0] bus
);

    localparam logic [16:0] FULL_LVL = 17'(DEPTH);

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_PEEK = 2'b10;

    localparam logic [2:0] SP_HOLD = 3'b000;
    localparam logic [2:0] SP_INC  = 3'b001;
    localparam logic [2:0] SP_DEC  = 3'b010;

    typedef enum logic [3:0] {
        IDLE,
        PUSH_X,
        POP_DEC,
        POP_RD,
        PEEK_DEC,
        PEEK_RD,
        PEEK_INC,
`ifdef STACK_CTRL_CLEAR_EN
        CLR,
`endif
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] data_q, data_d;
    logic [16:0]   depth_q, depth_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [2:0]    sp_ctrl_q, sp_ctrl_d;
    logic          mem_w_q, mem_w_d;
    logic          mem_s_q, mem_s_d;
    logic          full, empty;

    assign full  = (depth_q == FULL_LVL);
    assign empty = (depth_q == 17'd0);

    always_comb begin
        state_d = state_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        depth_d = depth_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_req) begin
                    wdata_d = i_data;
                    unique case (i_op)
                        OP_PUSH: begin
                            state_d = full ? DONE : PUSH_X;
                            err_d   = full;
                        end
                        OP_POP: begin
                            state_d = empty ? DONE : POP_DEC;
                            err_d   = empty;
                        end
                        OP_PEEK: begin
                            state_d = empty ? DONE : PEEK_DEC;
                            err_d   = empty;
                        end
                        default: begin
`ifdef STACK_CTRL_CLEAR_EN
                            state_d = empty ? DONE : CLR;
`else
                            state_d = DONE;
                            err_d   = 1'b1;
`endif
                        end
                    endcase
                end
            end
            PUSH_X: begin
                depth_d = depth_q + 17'd1;
                state_d = DONE;
            end
            POP_DEC: begin
                depth_d = depth_q - 17'd1;
                state_d = POP_RD;
            end
            POP_RD: begin
                data_d  = bus;
                state_d = DONE;
            end
            PEEK_DEC: state_d = PEEK_RD;
            PEEK_RD: begin
                data_d  = bus;
                state_d = PEEK_INC;
            end
            PEEK_INC: state_d = DONE;
`ifdef STACK_CTRL_CLEAR_EN
            CLR: begin
                depth_d = depth_q - 17'd1;
                if (depth_q == 17'd1) state_d = DONE;
            end
`endif
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with it.
    always_comb begin
        ready_d   = (state_d == IDLE);
        done_d    = (state_d == DONE);
        mem_w_d   = (state_d == PUSH_X);
        mem_s_d   = (state_d == POP_RD) || (state_d == PEEK_RD);
        sp_ctrl_d = SP_HOLD;
        unique case (state_d)
            PUSH_X, PEEK_INC:  sp_ctrl_d = SP_INC;
            POP_DEC, PEEK_DEC: sp_ctrl_d = SP_DEC;
`ifdef STACK_CTRL_CLEAR_EN
            CLR:               sp_ctrl_d = SP_DEC;
`endif
            default:           sp_ctrl_d = SP_HOLD;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= IDLE;
            wdata_q   <= '0;
            data_q    <= '0;
            depth_q   <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            sp_ctrl_q <= SP_HOLD;
            mem_w_q   <= 1'b0;
            mem_s_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wdata_q   <= wdata_d;
            data_q    <= data_d;
            depth_q   <= depth_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            err_q     <= err_d;
            sp_ctrl_q <= sp_ctrl_d;
            mem_w_q   <= mem_w_d;
            mem_s_q   <= mem_s_d;
        end
    end

    assign bus       = mem_w_q ? wdata_q : {DW{1'bz}};
    assign o_ready   = ready_q;
    assign o_done    = done_q;
    assign o_err     = err_q;
    assign o_data    = data_q;
    assign o_depth   = depth_q;
    assign o_full    = full;
    assign o_empty   = empty;
    assign o_sp_ctrl = sp_ctrl_q;
    assign o_mem_w   = mem_w_q;
    assign o_mem_s   = mem_s_q;

endmodule
